// File: rtl/adc_cfg_pkg.sv
// Shared ADC configuration constants: SPI register map, gain code width, full-scale
// sample values and the AGC state encoding.
package adc_cfg_pkg;

   localparam logic [4:0]  ADC_REG_FINE_GAIN = 5'h0C;
   localparam logic [4:0]  ADC_REG_SHUTDOWN  = 5'h00;

   localparam int unsigned GAIN_W    = 3;
   localparam int unsigned WR_ADDR_W = 5;
   localparam int unsigned WR_DATA_W = GAIN_W + 8;

   // Full-scale codes of the default 16-bit converter.
   localparam int unsigned ADC_W_DEF  = 16;
   localparam logic [15:0] ADC_FS_POS = 16'h7FFF;
   localparam logic [15:0] ADC_FS_NEG = 16'h8000;

   typedef enum logic [2:0] {
      StIdle,
      StInitWr,
      StMeasure,
      StReq,
      StSettle
   } agc_state_e;

   // Register payload for the fine-gain register: gain code in the top bits.
   function automatic logic [WR_DATA_W-1:0] gain_word(input logic [GAIN_W-1:0] gain);
      return {gain, 8'h00};
   endfunction

endpackage

// File: rtl/adc_ovl_detect.sv
// Overload detector: registered overrange pin and full-scale compare feeding a saturating
// event counter. With ADC_AGC_PEAK_EN defined it also tracks the per-window peak magnitude.
module adc_ovl_detect #(
   parameter int unsigned ADC_W   = 16,
   parameter int unsigned OVL_THR = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [ADC_W-1:0] adc_data,
   input  logic             adc_ovr,
   input  logic             clear,
`ifdef ADC_AGC_PEAK_EN
   input  logic             win_end,
   output logic [ADC_W-2:0] peak_level,
`endif
   output logic             ovl_any,
   output logic             ovl_hit
);

   localparam int unsigned      CNT_W  = $clog2(OVL_THR + 1);
   localparam logic [CNT_W-1:0] THR    = CNT_W'(OVL_THR);
   localparam logic [ADC_W-1:0] FS_POS = {1'b0, {(ADC_W-1){1'b1}}};
   localparam logic [ADC_W-1:0] FS_NEG = {1'b1, {(ADC_W-1){1'b0}}};

   logic             ovr_q;
   logic             fs_q;
   logic             evt;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_now;

   assign evt = ovr_q | fs_q;

   // Count including this cycle's event, so the terminal window cycle is not lost.
   assign cnt_now = (cnt_q >= THR) ? THR : cnt_q + CNT_W'(evt);
   assign ovl_any = (cnt_now != '0);
   assign ovl_hit = (cnt_now == THR);

   always_ff @(posedge clock) begin
      if (!reset) begin
         ovr_q <= 1'b0;
         fs_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         ovr_q <= adc_ovr;
         fs_q  <= (adc_data == FS_POS) || (adc_data == FS_NEG);
         cnt_q <= clear ? '0 : cnt_now;
      end
   end

`ifdef ADC_AGC_PEAK_EN
   logic [ADC_W-2:0] mag_d;
   logic [ADC_W-2:0] mag_q;
   logic [ADC_W-2:0] run_q;
   logic [ADC_W-2:0] run_now;

   // Low bits of the negation depend only on low bits; min negative clips to max magnitude.
   always_comb begin
      mag_d = adc_data[ADC_W-2:0];
      if (adc_data == FS_NEG) begin
         mag_d = {(ADC_W-1){1'b1}};
      end else if (adc_data[ADC_W-1]) begin
         mag_d = ~adc_data[ADC_W-2:0] + (ADC_W-1)'(1);
      end
   end

   assign run_now = (mag_q > run_q) ? mag_q : run_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         mag_q      <= '0;
         run_q      <= '0;
         peak_level <= '0;
      end else begin
         mag_q <= mag_d;
         run_q <= clear ? '0 : run_now;
         if (win_end) begin
            peak_level <= run_now;
         end
      end
   end
`endif

endmodule

// File: rtl/adc_agc.sv
// Automatic fine-gain controller: measures overloads per window and issues fine-gain
// register writes over a req/ack handshake. Define ADC_AGC_PEAK_EN to export peak_level.
module adc_agc
   import adc_cfg_pkg::*;
#(
   parameter int unsigned ADC_W       = 16,
   parameter int unsigned WIN_LEN     = 1000000,
   parameter int unsigned OVL_THR     = 16,
   parameter int unsigned REC_WINDOWS = 8,
   parameter int unsigned SETTLE      = 4096,
   parameter int unsigned GAIN_INIT   = 2,
   parameter int unsigned GAIN_MAX    = 6
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [ADC_W-1:0]     adc_data,
   input  logic                 adc_ovr,
   output logic                 wr_req,
   output logic [WR_ADDR_W-1:0] wr_addr,
   output logic [WR_DATA_W-1:0] wr_data,
   input  logic                 wr_ack,
   output logic [GAIN_W-1:0]    fine_gain,
`ifdef ADC_AGC_PEAK_EN
   output logic [ADC_W-2:0]     peak_level,
`endif
   output logic                 ovl_led
);

   localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned CLN_W = $clog2(REC_WINDOWS + 1);

   localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_LEN - 1);
   localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE - 1);
   localparam logic [CLN_W-1:0]  CLN_REC  = CLN_W'(REC_WINDOWS);
   localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(GAIN_INIT);
   localparam logic [GAIN_W-1:0] GAIN_TOP = GAIN_W'(GAIN_MAX);

   agc_state_e           state_q, state_d;
   logic [WIN_W-1:0]     win_q, win_d;
   logic [SET_W-1:0]     set_q, set_d;
   logic [CLN_W-1:0]     clean_q, clean_d, clean_inc;
   logic [GAIN_W-1:0]    gain_q, gain_d, gain_up, gain_dn;
   logic [WR_DATA_W-1:0] data_q, data_d;
   logic                 req_q, req_d;
   logic                 led_q, led_d;
   logic                 det_clear;
   logic                 win_last;
   logic                 ovl_any;
   logic                 ovl_hit;

   assign win_last  = (win_q == WIN_LAST);
   assign gain_up   = gain_q + GAIN_W'(1);
   assign gain_dn   = gain_q - GAIN_W'(1);
   assign clean_inc = (clean_q >= CLN_REC) ? CLN_REC : clean_q + CLN_W'(1);

   adc_ovl_detect #(
      .ADC_W   (ADC_W),
      .OVL_THR (OVL_THR)
   ) u_ovl_detect (
      .clock      (clock),
      .reset      (reset),
      .adc_data   (adc_data),
      .adc_ovr    (adc_ovr),
      .clear      (det_clear),
`ifdef ADC_AGC_PEAK_EN
      .win_end    ((state_q == StMeasure) && enable && win_last),
      .peak_level (peak_level),
`endif
      .ovl_any    (ovl_any),
      .ovl_hit    (ovl_hit)
   );

   always_comb begin
      state_d   = state_q;
      win_d     = '0;
      set_d     = '0;
      clean_d   = clean_q;
      gain_d    = gain_q;
      data_d    = data_q;
      req_d     = req_q;
      led_d     = led_q;
      det_clear = 1'b1;

      case (state_q)
         StIdle: begin
            if (enable) begin
               state_d = StInitWr;
            end
         end

         StInitWr: begin
            data_d  = gain_word(gain_q);
            req_d   = 1'b1;
            state_d = StReq;
         end

         StMeasure: begin
            det_clear = win_last || !enable;
            if (!enable) begin
               state_d = StIdle;
            end else if (!win_last) begin
               win_d = win_q + WIN_W'(1);
            end else begin
               led_d = ovl_any;
               if (ovl_hit) begin
                  clean_d = '0;
                  if (gain_q != '0) begin
                     data_d  = gain_word(gain_dn);
                     req_d   = 1'b1;
                     state_d = StReq;
                  end
               end else if (!ovl_any) begin
                  // Clean count saturates at REC_WINDOWS once the gain is at its ceiling.
                  if ((clean_inc == CLN_REC) && (gain_q < GAIN_TOP)) begin
                     clean_d = '0;
                     data_d  = gain_word(gain_up);
                     req_d   = 1'b1;
                     state_d = StReq;
                  end else begin
                     clean_d = clean_inc;
                  end
               end else begin
                  clean_d = '0;
               end
            end
         end

         StReq: begin
            // A request always runs to its ack; enable is only honoured afterwards.
            if (wr_ack) begin
               req_d   = 1'b0;
               gain_d  = data_q[WR_DATA_W-1 -: GAIN_W];
               state_d = enable ? StSettle : StIdle;
            end
         end

         StSettle: begin
            if (!enable) begin
               state_d = StIdle;
            end else if (set_q == SET_LAST) begin
               state_d = StMeasure;
            end else begin
               set_d = set_q + SET_W'(1);
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         win_q   <= '0;
         set_q   <= '0;
         clean_q <= '0;
         gain_q  <= GAIN_RST;
         data_q  <= gain_word(GAIN_RST);
         req_q   <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         set_q   <= set_d;
         clean_q <= clean_d;
         gain_q  <= gain_d;
         data_q  <= data_d;
         req_q   <= req_d;
         led_q   <= led_d;
      end
   end

   assign wr_req    = req_q;
   assign wr_addr   = ADC_REG_FINE_GAIN;
   assign wr_data   = data_q;
   assign fine_gain = gain_q;
   assign ovl_led   = led_q;

endmodule

// File: tb/tb_adc_agc.sv
// Self-checking bench for adc_agc: randomized windows of overload events checked against a
// window-level model of the gain rules.
module tb_adc_agc;

   localparam int WIN_LEN   = 64;
   localparam int OVL_THR   = 4;
   localparam int REC       = 2;
   localparam int SETTLE    = 8;
   localparam int GAIN_INIT = 2;
   localparam int GAIN_MAX  = 6;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] adc_data = 16'h0000;
   logic        adc_ovr = 1'b0;
   logic        wr_req;
   logic [4:0]  wr_addr;
   logic [10:0] wr_data;
   logic        wr_ack = 1'b0;
   logic [2:0]  fine_gain;
   logic        ovl_led;

   int checks = 0;
   int failures = 0;

   // Model state
   int gain_m  = GAIN_INIT;
   int clean_m = 0;
   bit led_m   = 1'b0;

   adc_agc #(
      .ADC_W       (16),
      .WIN_LEN     (WIN_LEN),
      .OVL_THR     (OVL_THR),
      .REC_WINDOWS (REC),
      .SETTLE      (SETTLE),
      .GAIN_INIT   (GAIN_INIT),
      .GAIN_MAX    (GAIN_MAX)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .adc_data  (adc_data),
      .adc_ovr   (adc_ovr),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .fine_gain (fine_gain),
      .ovl_led   (ovl_led)
   );

   always #5 clock = ~clock;

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] quiet();
      logic [15:0] v;
      v = 16'($urandom);
      if (v == 16'h7FFF || v == 16'h8000) v = 16'h0123;
      return v;
   endfunction

   function automatic logic [10:0] word(input int g);
      return {3'(g), 8'h00};
   endfunction

   // Window decision from the gain rules: n overload events observed in one window.
   function automatic void predict(input int n, output bit wr, output int ng, output int nc);
      wr = 1'b0;
      ng = gain_m;
      nc = clean_m;
      if (n >= OVL_THR) begin
         nc = 0;
         if (gain_m > 0) begin
            wr = 1'b1;
            ng = gain_m - 1;
         end
      end else if (n == 0) begin
         nc = clean_m + 1;
         if (nc >= REC) begin
            nc = REC;
            if (gain_m < GAIN_MAX) begin
               wr = 1'b1;
               ng = gain_m + 1;
               nc = 0;
            end
         end
      end else begin
         nc = 0;
      end
   endfunction

   task automatic do_ack(input int g, input int delay, input bit settle);
      bit pulse[SETTLE];
      int placed;
      for (int d = 0; d < delay; d++) begin
         checks++;
         if (wr_req !== 1'b1 || wr_data !== word(g)) begin
            failures++;
            $display("FAIL req_hold got=%0b/%h exp=1/%h", wr_req, wr_data, word(g));
         end
         tick();
      end
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      checks++;
      if (wr_req !== 1'b0) begin
         failures++;
         $display("FAIL req_drop got=%0b exp=0", wr_req);
      end
      checks++;
      if (fine_gain !== 3'(g)) begin
         failures++;
         $display("FAIL gain_commit got=%0d exp=%0d", fine_gain, g);
      end
      gain_m = g;
      if (settle) begin
         for (int s = 0; s < SETTLE; s++) pulse[s] = 1'b0;
         placed = 0;
         while (placed < 3) begin
            int p;
            p = $urandom_range(5, 0);
            if (!pulse[p]) begin
               pulse[p] = 1'b1;
               placed++;
            end
         end
         for (int s = 0; s < SETTLE; s++) begin
            adc_ovr  = pulse[s];
            adc_data = quiet();
            tick();
         end
         adc_ovr = 1'b0;
      end
   endtask

   task automatic enable_and_init(input int delay);
      int waited;
      enable = 1'b1;
      waited = 0;
      while (wr_req !== 1'b1 && waited < 10) begin
         tick();
         waited++;
      end
      checks++;
      if (wr_req !== 1'b1) begin
         failures++;
         $display("FAIL init_req got=%0b exp=1", wr_req);
         return;
      end
      checks++;
      if (wr_data !== word(gain_m) || wr_addr !== 5'h0C) begin
         failures++;
         $display("FAIL init_word got=%h@%h exp=%h@0c", wr_data, wr_addr, word(gain_m));
      end
      checks++;
      if (fine_gain !== 3'(gain_m)) begin
         failures++;
         $display("FAIL init_gain got=%0d exp=%0d", fine_gain, gain_m);
      end
      do_ack(gain_m, delay, 1'b1);
   endtask

   // mode 0: normal ack; 1: enable dropped during a long REQ; 2: reset during REQ
   task automatic run_window(input int n, input int mode);
      bit pos[WIN_LEN];
      int kind[WIN_LEN];
      int placed;
      int ack_at;
      bit wr;
      int ng;
      int nc;
      for (int i = 0; i < WIN_LEN; i++) begin
         pos[i]  = 1'b0;
         kind[i] = 0;
      end
      placed = 0;
      while (placed < n) begin
         int p;
         p = $urandom_range(55, 8);
         if (!pos[p]) begin
            pos[p]  = 1'b1;
            kind[p] = $urandom_range(2, 0);
            placed++;
         end
      end
      ack_at = $urandom_range(62, 0);
      predict(n, wr, ng, nc);
      for (int w = 0; w < WIN_LEN; w++) begin
         adc_data = quiet();
         adc_ovr  = 1'b0;
         wr_ack   = (w == ack_at);
         if (pos[w]) begin
            case (kind[w])
               0:       adc_ovr  = 1'b1;
               1:       adc_data = 16'h7FFF;
               default: adc_data = 16'h8000;
            endcase
         end
         if (w == 32) begin
            checks++;
            if (ovl_led !== led_m) begin
               failures++;
               $display("FAIL led_mid got=%0b exp=%0b", ovl_led, led_m);
            end
            checks++;
            if (wr_req !== 1'b0) begin
               failures++;
               $display("FAIL req_in_window got=%0b exp=0", wr_req);
            end
         end
         tick();
      end
      adc_ovr  = 1'b0;
      wr_ack   = 1'b0;
      adc_data = quiet();
      clean_m  = nc;
      led_m    = (n > 0);
      checks++;
      if (ovl_led !== led_m) begin
         failures++;
         $display("FAIL led_end got=%0b exp=%0b n=%0d", ovl_led, led_m, n);
      end
      checks++;
      if (wr_req !== wr) begin
         failures++;
         $display("FAIL win_req got=%0b exp=%0b n=%0d gain=%0d", wr_req, wr, n, gain_m);
      end
      if (wr && wr_req === 1'b1) begin
         checks++;
         if (wr_data !== word(ng) || wr_addr !== 5'h0C) begin
            failures++;
            $display("FAIL win_word got=%h@%h exp=%h@0c", wr_data, wr_addr, word(ng));
         end
         case (mode)
            0: do_ack(ng, $urandom_range(4, 0), 1'b1);
            1: begin
               enable = 1'b0;
               do_ack(ng, 200, 1'b0);
               for (int i = 0; i < 10; i++) begin
                  tick();
                  checks++;
                  if (wr_req !== 1'b0 || fine_gain !== 3'(ng)) begin
                     failures++;
                     $display("FAIL idle_hold got=%0b/%0d exp=0/%0d", wr_req, fine_gain, ng);
                  end
               end
            end
            default: begin
               tick();
               tick();
               reset = 1'b0;
               tick();
               checks++;
               if (wr_req !== 1'b0 || fine_gain !== 3'(GAIN_INIT)) begin
                  failures++;
                  $display("FAIL reset_mid_req got=%0b/%0d exp=0/%0d", wr_req, fine_gain,
                           GAIN_INIT);
               end
               checks++;
               if (wr_data !== word(GAIN_INIT) || ovl_led !== 1'b0) begin
                  failures++;
                  $display("FAIL reset_mid_out got=%h/%0b exp=%h/0", wr_data, ovl_led,
                           word(GAIN_INIT));
               end
               reset   = 1'b1;
               gain_m  = GAIN_INIT;
               clean_m = 0;
               led_m   = 1'b0;
            end
         endcase
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) tick();
      checks++;
      if (wr_req !== 1'b0 || wr_addr !== 5'h0C || wr_data !== 11'h200) begin
         failures++;
         $display("FAIL reset_bus got=%0b/%h/%h exp=0/0c/200", wr_req, wr_addr, wr_data);
      end
      checks++;
      if (fine_gain !== 3'(GAIN_INIT) || ovl_led !== 1'b0) begin
         failures++;
         $display("FAIL reset_status got=%0d/%0b exp=%0d/0", fine_gain, ovl_led, GAIN_INIT);
      end
      reset = 1'b1;
      tick();
      checks++;
      if (wr_req !== 1'b0) begin
         failures++;
         $display("FAIL idle_no_req got=%0b exp=0", wr_req);
      end
   endtask

   task automatic test_init_write();
      enable_and_init(3);
   endtask

   task automatic test_overload_decrease();
      run_window(5, 0);
      run_window(0, 0);
   endtask

   task automatic test_increase_to_max();
      int guard;
      guard = 0;
      while (gain_m < GAIN_MAX && guard < 20) begin
         run_window(0, 0);
         guard++;
      end
      repeat (4) run_window(0, 0);
   endtask

   task automatic test_decrease_to_zero();
      int guard;
      guard = 0;
      while (gain_m > 0 && guard < 10) begin
         run_window(10, 0);
         guard++;
      end
      repeat (3) run_window(10, 0);
   endtask

   task automatic test_enable_drop_in_req();
      bit wr;
      int ng;
      int nc;
      predict(0, wr, ng, nc);
      while (!wr) begin
         run_window(0, 0);
         predict(0, wr, ng, nc);
      end
      run_window(0, 1);
      enable_and_init(2);
   endtask

   task automatic test_reset_mid_req();
      run_window(10, 2);
      enable_and_init(1);
   endtask

   task automatic test_random();
      for (int k = 0; k < 30; k++) begin
         int n;
         case ($urandom_range(2, 0))
            0:       n = 0;
            1:       n = $urandom_range(3, 1);
            default: n = $urandom_range(12, 4);
         endcase
         run_window(n, 0);
      end
   endtask

   initial begin
      test_reset();
      test_init_write();
      test_overload_decrease();
      test_increase_to_max();
      test_decrease_to_zero();
      test_enable_drop_in_req();
      test_reset_mid_req();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_agc.md
Name: adc_agc

Overview:
- Automatic fine-gain controller upstream of the ADC SPI configuration master.
- Watches the ADC sample stream and overrange pin over fixed windows.
- Decides fine-gain steps (0–6 dB, 3-bit code) and issues register-write requests (address 5'h0C, data {gain,8'b0}) to the SPI writer over a req/ack handshake.
- Also exports current gain for status/telemetry.

Parameters:
ADC_W, 16, ADC sample width (two's complement)
WIN_LEN, 1000000, measurement window length in clock cycles
OVL_THR, 16, overload events in one window that force a gain decrease
REC_WINDOWS, 8, consecutive clean windows required before a gain increase
SETTLE, 4096, cycles after an acknowledged write during which overloads are ignored
GAIN_INIT, 2, fine-gain code after reset
GAIN_MAX, 6, highest legal fine-gain code

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
enable  in  1  AGC active; low = freeze gain, go IDLE
adc_data  in  ADC_W  sample, valid every clock
adc_ovr  in  1  ADC overrange pin, registered once internally
wr_req  out  1  write request to SPI writer
wr_addr  out  5  register address, constant 5'h0C
wr_data  out  11  {fine_gain, 8'b0}
wr_ack  in  1  one-cycle accept pulse from SPI writer
fine_gain  out  3  current committed gain code
ovl_led  out  1  high for the whole window following any window with ≥1 overload

Behaviour:
- Reset (reset==0 at clock edge), all outputs:
  - fine_gain=GAIN_INIT, wr_req=0, wr_addr=5'h0C, wr_data={GAIN_INIT,8'b0}, ovl_led=0.
  - Counters cleared; state IDLE.
- Overload event per cycle: registered adc_ovr==1, OR adc_data==max positive (0x7FFF), OR adc_data==min negative (0x8000).
  - Detection latency 1 cycle.
  - ovl_cnt increments per event and saturates at OVL_THR.
- States:
  - IDLE: wait for enable=1 -> INIT_WR.
  - INIT_WR: load wr_data={fine_gain,8'b0}, wr_req=1 -> REQ. Pushes the current gain at every enable rising.
  - MEASURE: win_cnt counts 0..WIN_LEN-1. At terminal count, evaluate:
    - ovl_cnt≥OVL_THR and fine_gain>0: gain-1, clean_cnt=0 -> REQ.
    - ovl_cnt≥OVL_THR and fine_gain==0: no write, clean_cnt=0.
    - ovl_cnt==0: clean_cnt+1. When it reaches REC_WINDOWS with fine_gain<GAIN_MAX: gain+1, clean_cnt=0 -> REQ. At GAIN_MAX, clean_cnt saturates at REC_WINDOWS with no write.
    - 0<ovl_cnt<OVL_THR: clean_cnt=0, no change.
    - ovl_cnt and win_cnt clear at window end.
  - REQ: wr_req held 1; wr_addr/wr_data stable until wr_ack sampled 1. Then wr_req=0 the next cycle and fine_gain commits the new code on the same edge -> SETTLE.
  - SETTLE: counts SETTLE cycles; overloads ignored -> MEASURE with cleared counters.
- Gain changes by at most 1 per window. No new request while REQ is outstanding.
- enable=0:
  - In MEASURE/SETTLE: -> IDLE next cycle.
  - In REQ: request completes (wait for ack) first, then IDLE. A request is never abandoned except by reset.
- Reset mid-REQ: wr_req drops on that edge.
- wr_ack outside REQ is ignored.
- Overload on the terminal window cycle counts toward that window.

Optional Feature:
- ADC_AGC_PEAK_EN defined:
  - Adds output peak_level[ADC_W-2:0], the absolute maximum sample magnitude of the last completed window. 0x8000 maps to 0x7FFF.
  - Updated at window end; reset 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package adc_cfg_pkg:
  - ADC_REG_FINE_GAIN=5'h0C, ADC_REG_SHUTDOWN=5'h00.
  - GAIN_W=3.
  - AGC state enum (IDLE, INIT_WR, MEASURE, REQ, SETTLE).
  - Full-scale constants.
- One sub-module adc_ovl_detect: registered overrange/full-scale detection plus saturating event counter with clear input. Optionally holds the peak tracker.

Test Plan (WIN_LEN=64, OVL_THR=4, REC_WINDOWS=2, SETTLE=8, GAIN_INIT=2):
- Reset then enable=1, wr_ack after 3 cycles -> one request, wr_data=11'h200; fine_gain stays 2; wr_req low the cycle after ack.
- 5 samples of 0x7FFF in one window -> request wr_data=11'h100 at window end; fine_gain=1 after ack; ovl_led high the next window.
- Quiet data, 2 clean windows after settle -> request wr_data=11'h300, fine_gain=3. Repeat until 6, then no further requests.
- fine_gain=0 with 10 overloads per window -> no request, wr_req stays 0.
- Hold wr_ack low 200 cycles during REQ with enable dropped -> wr_req and wr_data stay stable; after ack, IDLE with gain committed. Reset asserted mid-REQ -> wr_req=0 and fine_gain=2 next cycle.
- 3 adc_ovr pulses within the SETTLE window -> ignored; no gain change.
